// File: rtl/dispatch_unit_pkg.sv
// Shared constants and types for the dispatch (issue) stage.
// Holds the fixed widths, the "zero" encodings (NOP, RENAMED_ZERO, REG_ZERO,
// ZERO), boolean helpers and the issue-slot state encoding.
package dispatch_unit_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 6;
  localparam int ROB_W = 4;
  localparam int REG_W = 5;

  typedef logic [OP_W-1:0]  opcode_type_t;
  typedef logic [ROB_W-1:0] rob_id_range_t;
  typedef logic [XLEN-1:0]  data_idx_range_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam opcode_type_t    NOP          = '0;
  localparam rob_id_range_t   RENAMED_ZERO = '0;
  localparam reg_idx_t        REG_ZERO     = '0;
  localparam data_idx_range_t ZERO         = '0;
  localparam logic            TRUE         = 1'b1;
  localparam logic            FALSE        = 1'b0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_VALID = 1'b1
  } slot_state_t;

  // A CDB port hits a tag only for a live broadcast of a real (nonzero) alias.
  function automatic logic cdb_match(input logic          has_result,
                                     input rob_id_range_t bcast_id,
                                     input rob_id_range_t tag);
    return has_result && (tag != RENAMED_ZERO) && (bcast_id == tag);
  endfunction

endpackage

// File: rtl/dispatch_operand_resolve.sv
// Resolves one source operand at pop time: register 0, then the RF value,
// then a ROB entry that already holds its result, then a same-cycle CDB
// broadcast (ALU port before LSB port). Otherwise the rename tag is kept.
module dispatch_operand_resolve
  import dispatch_unit_pkg::*;
(
  input  logic [REG_W-1:0] reg_idx,
  input  logic [ROB_W-1:0] rf_q,
  input  logic [XLEN-1:0]  rf_v,
  input  logic             rob_rdy,
  input  logic [XLEN-1:0]  rob_val,
  input  logic             alu_has_result,
  input  logic [ROB_W-1:0] alu_alias,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             lsb_has_result,
  input  logic [ROB_W-1:0] lsb_alias,
  input  logic [XLEN-1:0]  lsb_result,
  output logic [ROB_W-1:0] q_o,
  output logic [XLEN-1:0]  v_o
);

  // Priority chain picking the freshest available source for the operand.
  always_comb begin
    q_o = RENAMED_ZERO;
    v_o = ZERO;
    if (reg_idx == REG_ZERO) begin
      q_o = RENAMED_ZERO;
      v_o = ZERO;
    end else if (rf_q == RENAMED_ZERO) begin
      v_o = rf_v;
    end else if (rob_rdy) begin
      v_o = rob_val;
    end else if (cdb_match(alu_has_result, alu_alias, rf_q)) begin
      v_o = alu_result;
    end else if (cdb_match(lsb_has_result, lsb_alias, rf_q)) begin
      v_o = lsb_result;
    end else begin
      q_o = rf_q;
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch unit: pops one decoded instruction per cycle from the IQ,
// allocates a ROB alias, renames rd, resolves operands and holds the result
// in a single registered issue slot towards the RS or the LSB.
// Optional perf counters are built when DISPATCH_PERF_EN is defined.
//
// Handshake: the slot is offered to its target (rdy_to_rs / rdy_to_lsb) while
// VALID and the target is not full; it is taken on every cycle where that
// offer is high, and a new IQ entry may be popped into the slot in the very
// same cycle, giving one issue per cycle.
module dispatch_unit
  import dispatch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             iq_valid,
  input  logic [OP_W-1:0]  iq_optype,
  input  logic [XLEN-1:0]  iq_pc,
  input  logic [REG_W-1:0] iq_rd,
  input  logic [REG_W-1:0] iq_rs1,
  input  logic [REG_W-1:0] iq_rs2,
  input  logic [XLEN-1:0]  iq_imm,
  input  logic             iq_is_ls,
  output logic             iq_pop,
  output logic [REG_W-1:0] rf_rs1,
  output logic [REG_W-1:0] rf_rs2,
  input  logic [ROB_W-1:0] rf_q1,
  input  logic [ROB_W-1:0] rf_q2,
  input  logic [XLEN-1:0]  rf_v1,
  input  logic [XLEN-1:0]  rf_v2,
  output logic             rf_rename_en,
  output logic [REG_W-1:0] rf_rename_rd,
  output logic [ROB_W-1:0] rf_rename_id,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_new_id,
  output logic             rob_alloc,
  output logic [REG_W-1:0] rob_alloc_rd,
  input  logic             rob_q1_rdy,
  input  logic             rob_q2_rdy,
  input  logic [XLEN-1:0]  rob_q1_val,
  input  logic [XLEN-1:0]  rob_q2_val,
  input  logic             alu_has_result,
  input  logic [ROB_W-1:0] alu_alias,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             lsb_has_result,
  input  logic [ROB_W-1:0] lsb_alias,
  input  logic [XLEN-1:0]  lsb_result,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             rdy_to_rs,
  output logic             rdy_to_lsb,
  output logic [OP_W-1:0]  out_optype,
  output logic [XLEN-1:0]  out_pc,
  output logic [ROB_W-1:0] out_alias,
  output logic [ROB_W-1:0] out_qi,
  output logic [ROB_W-1:0] out_qj,
  output logic [XLEN-1:0]  out_vi,
  output logic [XLEN-1:0]  out_vj,
  output logic [XLEN-1:0]  out_imm,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall,
`endif
  output slot_state_t      dbg_state
);

  slot_state_t     state_q;
  logic            is_ls_q;
  opcode_type_t    optype_q;
  data_idx_range_t pc_q, imm_q, vi_q, vj_q;
  rob_id_range_t   id_q, qi_q, qj_q;

  logic            tgt_full, consumed;
  rob_id_range_t   res_q1, res_q2;
  data_idx_range_t res_v1, res_v2;
  logic            qi_alu_hit, qi_lsb_hit, qj_alu_hit, qj_lsb_hit;
  logic            qi_hit, qj_hit;
  data_idx_range_t qi_cdb_val, qj_cdb_val;

  dispatch_operand_resolve u_res1 (
    .reg_idx        (iq_rs1),
    .rf_q           (rf_q1),
    .rf_v           (rf_v1),
    .rob_rdy        (rob_q1_rdy),
    .rob_val        (rob_q1_val),
    .alu_has_result (alu_has_result),
    .alu_alias      (alu_alias),
    .alu_result     (alu_result),
    .lsb_has_result (lsb_has_result),
    .lsb_alias      (lsb_alias),
    .lsb_result     (lsb_result),
    .q_o            (res_q1),
    .v_o            (res_v1)
  );

  dispatch_operand_resolve u_res2 (
    .reg_idx        (iq_rs2),
    .rf_q           (rf_q2),
    .rf_v           (rf_v2),
    .rob_rdy        (rob_q2_rdy),
    .rob_val        (rob_q2_val),
    .alu_has_result (alu_has_result),
    .alu_alias      (alu_alias),
    .alu_result     (alu_result),
    .lsb_has_result (lsb_has_result),
    .lsb_alias      (lsb_alias),
    .lsb_result     (lsb_result),
    .q_o            (res_q2),
    .v_o            (res_v2)
  );

  // Pop / consume decisions and the pass-through request signals.
  always_comb begin
    tgt_full     = is_ls_q ? lsb_full : rs_full;
    consumed     = (state_q == SLOT_VALID) && !tgt_full;
    iq_pop       = !rst && rdy && !rollback && iq_valid && !rob_full &&
                   ((state_q == SLOT_EMPTY) || consumed);
    rf_rs1       = iq_rs1;
    rf_rs2       = iq_rs2;
    rf_rename_en = iq_pop && (iq_rd != REG_ZERO);
    rf_rename_rd = iq_rd;
    rf_rename_id = rob_new_id;
    rob_alloc    = iq_pop;
    rob_alloc_rd = iq_rd;
  end

  // CDB snooping of the waiting slot operands (ALU port has priority).
  always_comb begin
    qi_alu_hit = cdb_match(alu_has_result, alu_alias, qi_q);
    qi_lsb_hit = cdb_match(lsb_has_result, lsb_alias, qi_q);
    qj_alu_hit = cdb_match(alu_has_result, alu_alias, qj_q);
    qj_lsb_hit = cdb_match(lsb_has_result, lsb_alias, qj_q);
    qi_hit     = qi_alu_hit || qi_lsb_hit;
    qj_hit     = qj_alu_hit || qj_lsb_hit;
    qi_cdb_val = qi_alu_hit ? alu_result : lsb_result;
    qj_cdb_val = qj_alu_hit ? alu_result : lsb_result;
  end

  // Issue-slot outputs, with same-cycle broadcasts folded in for the consumer.
  always_comb begin
    rdy_to_rs  = (state_q == SLOT_VALID) && !is_ls_q && !rs_full;
    rdy_to_lsb = (state_q == SLOT_VALID) &&  is_ls_q && !lsb_full;
    out_optype = optype_q;
    out_pc     = pc_q;
    out_alias  = id_q;
    out_imm    = imm_q;
    out_qi     = qi_hit ? RENAMED_ZERO : qi_q;
    out_vi     = qi_hit ? qi_cdb_val   : vi_q;
    out_qj     = qj_hit ? RENAMED_ZERO : qj_q;
    out_vj     = qj_hit ? qj_cdb_val   : vj_q;
    dbg_state  = state_q;
  end

  // Slot FSM: load on pop, drain on consume, snoop the CDB while held.
  always_ff @(posedge clk) begin
    if (rst || (rdy && rollback)) begin
      state_q  <= SLOT_EMPTY;
      is_ls_q  <= FALSE;
      optype_q <= NOP;
      pc_q     <= ZERO;
      imm_q    <= ZERO;
      id_q     <= RENAMED_ZERO;
      qi_q     <= RENAMED_ZERO;
      qj_q     <= RENAMED_ZERO;
      vi_q     <= ZERO;
      vj_q     <= ZERO;
    end else if (rdy) begin
      case (state_q)
        SLOT_EMPTY: begin
          if (iq_pop) state_q <= SLOT_VALID;
        end
        SLOT_VALID: begin
          if (consumed && !iq_pop) state_q <= SLOT_EMPTY;
        end
        default: state_q <= SLOT_EMPTY;
      endcase
      if (iq_pop) begin
        is_ls_q  <= iq_is_ls;
        optype_q <= iq_optype;
        pc_q     <= iq_pc;
        imm_q    <= iq_imm;
        id_q     <= rob_new_id;
        qi_q     <= res_q1;
        vi_q     <= res_v1;
        qj_q     <= res_q2;
        vj_q     <= res_v2;
      end else if ((state_q == SLOT_VALID) && !consumed) begin
        if (qi_hit) begin
          qi_q <= RENAMED_ZERO;
          vi_q <= qi_cdb_val;
        end
        if (qj_hit) begin
          qj_q <= RENAMED_ZERO;
          vj_q <= qj_cdb_val;
        end
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  // Wrapping issue and stall counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else if (rdy) begin
      if (consumed) perf_issued_q <= perf_issued_q + 32'd1;
      if (iq_valid && !iq_pop && !rollback) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed testbench for dispatch_unit with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic             clk, rst, rdy, rollback;
  logic             iq_valid, iq_is_ls;
  logic [OP_W-1:0]  iq_optype;
  logic [XLEN-1:0]  iq_pc, iq_imm;
  logic [REG_W-1:0] iq_rd, iq_rs1, iq_rs2;
  logic             iq_pop;
  logic [REG_W-1:0] rf_rs1, rf_rs2;
  logic [ROB_W-1:0] rf_q1, rf_q2;
  logic [XLEN-1:0]  rf_v1, rf_v2;
  logic             rf_rename_en;
  logic [REG_W-1:0] rf_rename_rd;
  logic [ROB_W-1:0] rf_rename_id;
  logic             rob_full;
  logic [ROB_W-1:0] rob_new_id;
  logic             rob_alloc;
  logic [REG_W-1:0] rob_alloc_rd;
  logic             rob_q1_rdy, rob_q2_rdy;
  logic [XLEN-1:0]  rob_q1_val, rob_q2_val;
  logic             alu_has_result, lsb_has_result;
  logic [ROB_W-1:0] alu_alias, lsb_alias;
  logic [XLEN-1:0]  alu_result, lsb_result;
  logic             rs_full, lsb_full;
  logic             rdy_to_rs, rdy_to_lsb;
  logic [OP_W-1:0]  out_optype;
  logic [XLEN-1:0]  out_pc, out_vi, out_vj, out_imm;
  logic [ROB_W-1:0] out_alias, out_qi, out_qj;
  slot_state_t      dbg_state;
`ifdef DISPATCH_PERF_EN
  logic [31:0]      perf_issued, perf_stall;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  dispatch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .iq_valid(iq_valid), .iq_optype(iq_optype), .iq_pc(iq_pc),
    .iq_rd(iq_rd), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_imm(iq_imm),
    .iq_is_ls(iq_is_ls), .iq_pop(iq_pop),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_q1(rf_q1), .rf_q2(rf_q2),
    .rf_v1(rf_v1), .rf_v2(rf_v2),
    .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd), .rf_rename_id(rf_rename_id),
    .rob_full(rob_full), .rob_new_id(rob_new_id),
    .rob_alloc(rob_alloc), .rob_alloc_rd(rob_alloc_rd),
    .rob_q1_rdy(rob_q1_rdy), .rob_q2_rdy(rob_q2_rdy),
    .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
    .alu_has_result(alu_has_result), .alu_alias(alu_alias), .alu_result(alu_result),
    .lsb_has_result(lsb_has_result), .lsb_alias(lsb_alias), .lsb_result(lsb_result),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .rdy_to_rs(rdy_to_rs), .rdy_to_lsb(rdy_to_lsb),
    .out_optype(out_optype), .out_pc(out_pc), .out_alias(out_alias),
    .out_qi(out_qi), .out_qj(out_qj), .out_vi(out_vi), .out_vj(out_vj),
    .out_imm(out_imm),
`ifdef DISPATCH_PERF_EN
    .perf_issued(perf_issued), .perf_stall(perf_stall),
`endif
    .dbg_state(dbg_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may then be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rollback = 0; iq_valid = 0; iq_is_ls = 0; iq_optype = '0; iq_pc = '0;
    iq_rd = '0; iq_rs1 = '0; iq_rs2 = '0; iq_imm = '0;
    rf_q1 = '0; rf_q2 = '0; rf_v1 = '0; rf_v2 = '0;
    rob_full = 0; rob_new_id = '0;
    rob_q1_rdy = 0; rob_q2_rdy = 0; rob_q1_val = '0; rob_q2_val = '0;
    alu_has_result = 0; alu_alias = '0; alu_result = '0;
    lsb_has_result = 0; lsb_alias = '0; lsb_result = '0;
  endtask

  task automatic drive_instr(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rd,
                             input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                             input logic [ROB_W-1:0] new_id, input logic is_ls);
    iq_valid = 1; iq_optype = op; iq_rd = rd; iq_rs1 = rs1; iq_rs2 = rs2;
    rob_new_id = new_id; iq_is_ls = is_ls;
    iq_pc = 32'h1000 + {28'd0, new_id} * 4; iq_imm = 32'h20;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    iq_valid = 1; rob_new_id = 4'd1;
    tick();
    settle();
    check("pop_in_reset", iq_pop, 0);
    tick();
    rst = 0; iq_valid = 0;
  endtask

  initial begin
    rdy = 1; rs_full = 0; lsb_full = 0;
    do_reset();
    settle();
    check("rst_rdy_to_rs", rdy_to_rs, 0);
    check("rst_rdy_to_lsb", rdy_to_lsb, 0);
    check("rst_iq_pop", iq_pop, 0);
    check("rst_out_optype", out_optype, 0);
    check("rst_out_alias", out_alias, 0);
    check("rst_out_vi", out_vi, 0);
    check("rst_dbg_state", dbg_state, SLOT_EMPTY);

    // ADD x3,x1,x2 with both operands in the RF.
    drive_instr(6'd1, 5'd3, 5'd1, 5'd2, 4'd3, 0);
    rf_v1 = 32'd5; rf_v2 = 32'd7;
    settle();
    check("add_pop", iq_pop, 1);
    check("add_rename_en", rf_rename_en, 1);
    check("add_rename_rd", rf_rename_rd, 3);
    check("add_rename_id", rf_rename_id, 3);
    check("add_rob_alloc", rob_alloc, 1);
    tick();
    idle_inputs();
    settle();
    check("add_rdy_to_rs", rdy_to_rs, 1);
    check("add_rdy_to_lsb", rdy_to_lsb, 0);
    check("add_alias", out_alias, 3);
    check("add_vi", out_vi, 5);
    check("add_vj", out_vj, 7);
    check("add_qi", out_qi, 0);
    check("add_qj", out_qj, 0);
    check("add_optype", out_optype, 1);
    check("add_pc", out_pc, 32'h100c);

    // rs1 waits on alias 4; the ALU broadcasts it the cycle after pop.
    drive_instr(6'd2, 5'd5, 5'd6, 5'd7, 4'd5, 0);
    rf_q1 = 4'd4; rf_v2 = 32'd11;
    tick();
    idle_inputs();
    settle();
    check("pend_qi", out_qi, 4);
    check("pend_vj", out_vj, 11);
    alu_has_result = 1; alu_alias = 4'd4; alu_result = 32'h55;
    settle();
    check("cdb_bypass_qi", out_qi, 0);
    check("cdb_bypass_vi", out_vi, 32'h55);

    // rs1 from a ready ROB entry, rs2 from a same-cycle LSB broadcast.
    idle_inputs();
    drive_instr(6'd2, 5'd8, 5'd4, 5'd3, 4'd6, 0);
    rf_q1 = 4'd6; rob_q1_rdy = 1; rob_q1_val = 32'h77;
    rf_q2 = 4'd8; lsb_has_result = 1; lsb_alias = 4'd8; lsb_result = 32'h88;
    tick();
    // Register 0 wins even over a nonzero stale tag.
    idle_inputs();
    drive_instr(6'd2, 5'd9, 5'd0, 5'd0, 4'd7, 0);
    rf_q1 = 4'd9; rf_v1 = 32'hdead; rf_q2 = 4'd9; rf_v2 = 32'hbeef;
    settle();
    check("rob_qi", out_qi, 0);
    check("rob_vi", out_vi, 32'h77);
    check("popcdb_qj", out_qj, 0);
    check("popcdb_vj", out_vj, 32'h88);
    tick();
    idle_inputs();
    settle();
    check("x0_qi", out_qi, 0);
    check("x0_vi", out_vi, 0);
    check("x0_vj", out_vj, 0);
    tick();

    // Hold while RS is full; LSB broadcast clears Qj during the hold.
    drive_instr(6'd3, 5'd10, 5'd1, 5'd2, 4'd9, 0);
    rf_v1 = 32'd1; rf_q2 = 4'd7;
    tick();
    idle_inputs();
    rs_full = 1;
    drive_instr(6'd4, 5'd11, 5'd1, 5'd2, 4'd10, 0);
    settle();
    check("hold1_pop", iq_pop, 0);
    check("hold1_rdy", rdy_to_rs, 0);
    check("hold1_qj", out_qj, 7);
    tick();
    lsb_has_result = 1; lsb_alias = 4'd7; lsb_result = 32'd9;
    settle();
    check("hold2_pop", iq_pop, 0);
    check("hold2_rdy", rdy_to_rs, 0);
    tick();
    lsb_has_result = 0; lsb_alias = '0; lsb_result = '0;
    settle();
    check("hold3_pop", iq_pop, 0);
    check("hold3_rdy", rdy_to_rs, 0);
    check("hold3_qj", out_qj, 0);
    check("hold3_vj", out_vj, 9);
    tick();
    idle_inputs();
    rs_full = 0;
    settle();
    check("release_rdy", rdy_to_rs, 1);
    check("release_vj", out_vj, 9);
    check("release_alias", out_alias, 9);
    tick();
    settle();
    check("drained", dbg_state, SLOT_EMPTY);

    // Load routed to the LSB while the RS is full; ROB full blocks the pop.
    rs_full = 1;
    drive_instr(6'd5, 5'd12, 5'd1, 5'd0, 4'd11, 1);
    tick();
    idle_inputs();
    settle();
    check("ld_rdy_lsb", rdy_to_lsb, 1);
    check("ld_rdy_rs", rdy_to_rs, 0);
    drive_instr(6'd5, 5'd13, 5'd1, 5'd0, 4'd12, 1);
    rob_full = 1;
    settle();
    check("robfull_pop", iq_pop, 0);
    tick();
    idle_inputs();
    settle();
    check("ld_drained", rdy_to_lsb, 0);
    rs_full = 0;

    // Rollback while the slot is held and the IQ has an entry.
    drive_instr(6'd1, 5'd14, 5'd1, 5'd2, 4'd13, 0);
    tick();
    rs_full = 1;
    drive_instr(6'd1, 5'd15, 5'd1, 5'd2, 4'd14, 0);
    rollback = 1;
    settle();
    check("rb_pop", iq_pop, 0);
    check("rb_rename", rf_rename_en, 0);
    tick();
    idle_inputs();
    rs_full = 0;
    settle();
    check("rb_rdy_rs", rdy_to_rs, 0);
    check("rb_rdy_lsb", rdy_to_lsb, 0);
    check("rb_optype", out_optype, 0);
    check("rb_alias", out_alias, 0);

    // Back-to-back pops with rd = x0: no rename, one issue per cycle.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      drive_instr(6'd1, 5'd0, 5'd1, 5'd0, 4'(i + 1), 0);
      rf_v1 = 32'(10 + i);
      settle();
      check("b2b_pop", iq_pop, 1);
      check("b2b_rename", rf_rename_en, 0);
      tick();
      settle();
      check("b2b_rdy", rdy_to_rs, 1);
      check("b2b_alias", out_alias, 32'(i + 1));
      check("b2b_vi", out_vi, 32'(10 + i));
    end

    // rdy low freezes the slot even though it would be consumed.
    idle_inputs();
    rdy = 0;
    iq_valid = 1; rob_new_id = 4'd5;
    settle();
    check("frz_pop", iq_pop, 0);
    tick();
    settle();
    check("frz_rdy", rdy_to_rs, 1);
    check("frz_alias", out_alias, 3);
    idle_inputs();
    rdy = 1;
    tick();
    settle();
    check("unfrz_rdy", rdy_to_rs, 0);

`ifdef DISPATCH_PERF_EN
    // Fresh reset; 4 issues and 2 stall cycles.
    do_reset();
    drive_instr(6'd1, 5'd1, 5'd0, 5'd0, 4'd1, 0);
    tick();
    drive_instr(6'd1, 5'd2, 5'd0, 5'd0, 4'd2, 0);
    tick();
    rs_full = 1;
    drive_instr(6'd1, 5'd3, 5'd0, 5'd0, 4'd3, 0);
    tick();
    tick();
    rs_full = 0;
    tick();
    drive_instr(6'd1, 5'd4, 5'd0, 5'd0, 4'd4, 0);
    tick();
    idle_inputs();
    tick();
    settle();
    check("perf_issued", perf_issued, 4);
    check("perf_stall", perf_stall, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Issue stage directly upstream of the reservation station (RS) and the load/store buffer (LSB).
- Each cycle it pops at most one decoded instruction from the instruction queue (IQ), allocates a ROB alias, and renames rd.
- It resolves rs1/rs2 through the register-file rename table and the ROB.
- It presents a single registered issue slot to RS or LSB, tracks CDB broadcasts while the slot waits, and holds the slot while the target is full.

Parameters:
- XLEN, 32, data/PC width
- OP_W, 6, optype width; optype 0 = NOP
- ROB_W, 4, ROB alias width; alias 0 = RENAMED_ZERO (operand ready)
- REG_W, 5, architectural register index width

Ports:
- clk in 1 clock
- rst in 1 synchronous active-high reset
- rdy in 1 global enable; low = freeze all state
- rollback in 1 misprediction flush
- iq_valid in 1 IQ head valid
- iq_optype in OP_W decoded op
- iq_pc in XLEN instruction PC
- iq_rd/iq_rs1/iq_rs2 in REG_W register indices
- iq_imm in XLEN immediate
- iq_is_ls in 1 1 = route to LSB, 0 = route to RS
- iq_pop out 1 combinational pop strobe
- rf_rs1/rf_rs2 out REG_W combinational read addresses
- rf_q1/rf_q2 in ROB_W rename tags (0 = value in RF)
- rf_v1/rf_v2 in XLEN RF values
- rf_rename_en out 1, rf_rename_rd out REG_W, rf_rename_id out ROB_W: tag write, same cycle as pop
- rob_full in 1; rob_new_id in ROB_W next free alias (nonzero)
- rob_alloc out 1 (= iq_pop), rob_alloc_rd out REG_W
- rob_q1_rdy/rob_q2_rdy in 1 ROB entry rf_q* already has a value
- rob_q1_val/rob_q2_val in XLEN that value
- alu_has_result in 1, alu_alias in ROB_W, alu_result in XLEN: CDB port A
- lsb_has_result in 1, lsb_alias in ROB_W, lsb_result in XLEN: CDB port B
- rs_full in 1; lsb_full in 1
- rdy_to_rs out 1; rdy_to_lsb out 1
- out_optype out OP_W; out_pc out XLEN; out_alias out ROB_W
- out_qi/out_qj out ROB_W; out_vi/out_vj out XLEN; out_imm out XLEN

Behaviour:
- Slot state: EMPTY or VALID. Slot fields are registered.
- tgt_full = slot_is_ls ? lsb_full : rs_full.
- consumed = VALID && !tgt_full.
- iq_pop = rdy && !rollback && iq_valid && !rob_full && (EMPTY || consumed).
- On pop, at the next edge:
  - slot <= VALID.
  - alias <= rob_new_id.
  - Operand k: if rf_qk == 0, then Q = 0 and V = rf_vk. Else if rob_qk_rdy, then Q = 0 and V = rob_qk_val. Else if the CDB (ALU first, then LSB) matches rf_qk in this cycle, then Q = 0 and V = the CDB result. Otherwise Q = rf_qk.
  - Index 0 always yields Q = 0, V = 0.
- rf_rename_en = iq_pop && iq_rd != 0. Same-cycle rename of rd == rs1 does not affect this instruction's lookup; RF read is pre-write.
- consumed with no pop: slot <= EMPTY.
- Slot VALID and !consumed: hold all fields, but each cycle clear Q/V on a CDB match (either port).
- rdy_to_rs = VALID && !slot_is_ls && !rs_full; rdy_to_lsb likewise.
- out_q*/out_v* are combinational overrides of the slot, applied to CDB matches in the current cycle. The consumer never misses a same-cycle broadcast.
- Both CDB ports matching the same nonzero alias is illegal; ALU wins.
- Latency: pop to visible issue is 1 cycle. Throughput is 1 per cycle while the target is not full.
- rollback, or rst, at the edge:
  - slot <= EMPTY, out_optype <= NOP.
  - Q/V/alias <= 0.
  - No pop and no rename that cycle.
- Reset values: rdy_to_rs = 0, rdy_to_lsb = 0, iq_pop = 0, all out_* = 0.
- rdy low: all registers hold; iq_pop = 0.

Optional Feature:
- Macro DISPATCH_PERF_EN.
- Defined: adds outputs perf_issued [31:0] (count of consumed slots) and perf_stall [31:0] (cycles with iq_valid && !iq_pop && !rollback). Both are wrapping counters, cleared by rst only.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared const package holds: NOP, RENAMED_ZERO, REG_ZERO, ZERO, TRUE/FALSE, the OPCODE_TYPE / ROB_ID_RANGE / DATA_IDX_RANGE ranges.
- One sub-module, dispatch_operand_resolve, instantiated twice. Inputs: rf q/v, rob rdy/val, both CDB ports, register index. Outputs: resolved Q/V.

Test Plan:
- Reset, then iq_valid with ADD x3,x1,x2, rf_q1 = rf_q2 = 0, rf_v1 = 5, rf_v2 = 7, rob_new_id = 3 -> iq_pop = 1. Next cycle: rdy_to_rs = 1, out_alias = 3, out_vi = 5, out_vj = 7, out_qi = out_qj = 0, rf_rename_rd = 3.
- rf_q1 = 4, rob_q1_rdy = 0, no CDB; next cycle alu_has_result with alias 4, result 0x55 -> out_qi = 0, out_vi = 0x55 in that same cycle.
- Slot VALID and rs_full = 1 for 3 cycles -> iq_pop = 0 and rdy_to_rs = 0 throughout. During the hold, lsb_has_result alias = Qj, result 9 -> slot Qj = 0, Vj = 9. rs_full drops -> rdy_to_rs = 1 with Vj = 9.
- Load with iq_is_ls = 1 and lsb_full = 0 -> rdy_to_lsb = 1, rdy_to_rs = 0. rob_full = 1 -> iq_pop = 0.
- rollback while slot VALID and iq_valid = 1 -> next cycle both rdy outputs 0, out_optype = NOP, no rename. Back-to-back pops (iq_rd = 0) -> rf_rename_en = 0, one issue per cycle.
- DISPATCH_PERF_EN: 4 issues plus 2 stall cycles -> perf_issued = 4, perf_stall = 2.
